// File: rtl/dut_if_pkg.sv
// Shared constants for the incr_decr operation driver: state encoding, data width, scan length.
package dut_if_pkg;
  localparam int DUT_DW       = 32;
  localparam int SCAN_LEN_DEF = 32;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_REQ         = 3'd1;
  localparam logic [2:0] ST_WAIT_COMMIT = 3'd2;
  localparam logic [2:0] ST_ACK         = 3'd3;
  localparam logic [2:0] ST_SCAN        = 3'd4;
  localparam logic [2:0] ST_RESP        = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE        = ST_IDLE,
    S_REQ         = ST_REQ,
    S_WAIT_COMMIT = ST_WAIT_COMMIT,
    S_ACK         = ST_ACK,
    S_SCAN        = ST_SCAN,
    S_RESP        = ST_RESP
  } state_t;
endpackage

// File: rtl/dut_op_driver_if.sv
// Host command/response plus DUT op/commit/scan signals; master is the driver side.
interface dut_op_driver_if #(parameter int SCAN_LEN = dut_if_pkg::SCAN_LEN_DEF);
  import dut_if_pkg::*;

  logic              cmd_val;
  logic              cmd_rdy;
  logic [DUT_DW-1:0] cmd_data;
  logic              cmd_scan;
  logic              rsp_val;
  logic              rsp_rdy;
  logic [DUT_DW-1:0] rsp_data;
  logic [SCAN_LEN-1:0] rsp_scan;
  logic              rsp_err;
  logic [DUT_DW-1:0] data_in;
  logic [DUT_DW-1:0] data_out;
  logic              val_op;
  logic              op_ack;
  logic              op_commit;
  logic              commit_ack;
  logic              sen;
  logic              scan_ce;
  logic              sin;
  logic              sout;

  modport master (
    input  cmd_val, cmd_data, cmd_scan, rsp_rdy, data_out, op_ack, op_commit, sout,
    output cmd_rdy, rsp_val, rsp_data, rsp_scan, rsp_err, data_in, val_op,
           commit_ack, sen, scan_ce, sin
  );

  modport slave (
    output cmd_val, cmd_data, cmd_scan, rsp_rdy, data_out, op_ack, op_commit, sout,
    input  cmd_rdy, rsp_val, rsp_data, rsp_scan, rsp_err, data_in, val_op,
           commit_ack, sen, scan_ce, sin
  );
endinterface

// File: rtl/scan_unloader.sv
// Shifts the DUT scan chain SCAN_LEN times after start, recirculating sout into sin so the
// chain is restored, and captures the bits with the first-shifted bit ending at [0].
module scan_unloader #(
  parameter int SCAN_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clr,
  output logic                done,
  output logic                sen,
  output logic                scan_ce,
  output logic                sin,
  input  logic                sout,
  output logic [SCAN_LEN-1:0] scan_dat
);
  localparam int CW = $clog2(SCAN_LEN + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [SCAN_LEN:0] shifted;

  assign shifted = {sout, scan_dat};
  assign done    = busy && (cnt == CW'(SCAN_LEN - 1));
  assign sen     = busy;
  assign scan_ce = busy;
  assign sin     = busy & sout;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= '0;
      scan_dat <= '0;
    end else begin
      if (clr) scan_dat <= '0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (busy) begin
        scan_dat <= shifted[SCAN_LEN:1];
        cnt      <= cnt + 1'b1;
        if (done) busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dut_op_driver.sv
// Drives one op/commit handshake into incr_decr per host command, optionally unloads the
// scan chain, then holds a single response until the host takes it.
module dut_op_driver
  import dut_if_pkg::*;
#(
  parameter int SCAN_LEN = SCAN_LEN_DEF,
  parameter int TIMEOUT  = 1024
) (
  input logic clk,
  input logic reset,
  dut_op_driver_if.master io
);
  localparam int TW = $clog2(TIMEOUT);

  state_t              state, state_nxt;
  logic [TW-1:0]       wait_cnt;
  logic                wait_expired;
  logic                scan_flag;
  logic [DUT_DW-1:0]   data_in_q;
  logic [DUT_DW-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic [SCAN_LEN-1:0] scan_dat;
  logic                scan_done;

  assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        if (io.cmd_val) state_nxt = S_REQ;
      S_REQ:         if (io.op_ack) state_nxt = S_WAIT_COMMIT;
                     else if (wait_expired) state_nxt = S_RESP;
      S_WAIT_COMMIT: if (io.op_commit) state_nxt = S_ACK;
                     else if (wait_expired) state_nxt = S_RESP;
      S_ACK:         state_nxt = scan_flag ? S_SCAN : S_RESP;
      S_SCAN:        if (scan_done) state_nxt = S_RESP;
      S_RESP:        if (io.rsp_rdy) state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      scan_flag  <= 1'b0;
      data_in_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      // One counter serves both waits; every state change restarts it.
      if (state_nxt != state) wait_cnt <= '0;
      else if (state == S_REQ || state == S_WAIT_COMMIT) wait_cnt <= wait_cnt + 1'b1;
      case (state)
        S_IDLE: if (io.cmd_val) begin
          data_in_q <= io.cmd_data;
          scan_flag <= io.cmd_scan;
          rsp_err_q <= 1'b0;
        end
        S_REQ: if (!io.op_ack && wait_expired) begin
          rsp_err_q  <= 1'b1;
          rsp_data_q <= '0;
        end
        S_WAIT_COMMIT: if (io.op_commit) begin
          rsp_data_q <= io.data_out;
        end else if (wait_expired) begin
          rsp_err_q  <= 1'b1;
          rsp_data_q <= '0;
        end
        default: ;
      endcase
    end
  end

  scan_unloader #(.SCAN_LEN(SCAN_LEN)) u_scan (
    .clk      (clk),
    .reset    (reset),
    .start    (state == S_ACK && scan_flag),
    .clr      (state == S_IDLE && io.cmd_val),
    .done     (scan_done),
    .sen      (io.sen),
    .scan_ce  (io.scan_ce),
    .sin      (io.sin),
    .sout     (io.sout),
    .scan_dat (scan_dat)
  );

  assign io.cmd_rdy    = (state == S_IDLE);
  assign io.val_op     = (state == S_REQ);
  assign io.commit_ack = (state == S_ACK);
  assign io.rsp_val    = (state == S_RESP);
  assign io.data_in    = data_in_q;
  assign io.rsp_data   = rsp_data_q;
  assign io.rsp_err    = rsp_err_q;
  assign io.rsp_scan   = scan_dat;
endmodule

// File: tb/tb_dut_op_driver.sv
// Directed bench for dut_op_driver with a reactive incr_decr stand-in and a response model.
module tb_dut_op_driver;
  localparam int SL = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dut_op_driver_if #(.SCAN_LEN(SL)) bus ();
  dut_op_driver #(.SCAN_LEN(SL), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .io(bus));

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [31:0] scan;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0, n_fail = 0;
  int n_val = 0, n_cack = 0, n_sen = 0, n_sce = 0;
  logic tb_busy = 1'b0;
  logic [31:0] tb_cmd = '0;
  logic [31:0] chain = '0, chain_init = '0;
  logic chain_ld = 1'b0;

  int cfg_ack_at = 0, cfg_commit_after = 1;
  logic [31:0] cfg_dout = '0;
  bit cfg_both = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response a command must produce, from the ack timing and the DUT's commit data.
  function automatic exp_t model(input int ack_at, input logic [31:0] dout, input bit sc,
                                 input logic [31:0] ch);
    exp_t e;
    if (ack_at < 0 || ack_at >= TO) e = '{err: 1'b1, data: 32'h0, scan: 32'h0};
    else e = '{err: 1'b0, data: dout, scan: sc ? ch : 32'h0};
    return e;
  endfunction

  // Scan chain of the DUT stand-in: shifts toward bit 0, sout is bit 0.
  assign bus.sout = chain[0];
  always @(posedge clk) begin
    if (chain_ld) chain <= chain_init;
    else if (bus.scan_ce) chain <= {bus.sin, chain[31:1]};
  end

  // incr_decr stand-in: ack after cfg_ack_at cycles of val_op, commit cfg_commit_after later.
  initial begin : responder
    int vcnt, ccnt, hold;
    vcnt = 0; ccnt = 0; hold = 0;
    bus.op_ack = 1'b0; bus.op_commit = 1'b0; bus.data_out = '0;
    forever begin
      @(posedge clk); #1;
      bus.op_ack = 1'b0; bus.op_commit = 1'b0;
      if (hold > 0) begin
        bus.op_ack = 1'b1; bus.op_commit = 1'b1; hold--;
      end else if (bus.val_op) begin
        if (vcnt == cfg_ack_at) begin
          bus.op_ack = 1'b1;
          if (cfg_both) begin
            bus.op_commit = 1'b1; bus.data_out = cfg_dout; hold = 1;
          end else ccnt = cfg_commit_after;
        end
        vcnt++;
      end else begin
        vcnt = 0;
        if (ccnt > 0) begin
          ccnt--;
          if (ccnt == 0) begin bus.op_commit = 1'b1; bus.data_out = cfg_dout; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.val_op) n_val++;
    if (bus.commit_ack) n_cack++;
    if (bus.sen) n_sen++;
    if (bus.scan_ce) n_sce++;
  end

  always @(posedge clk) begin
    if (reset) tb_busy <= 1'b0;
    else begin
      if (bus.cmd_val && bus.cmd_rdy) begin tb_busy <= 1'b1; tb_cmd <= bus.cmd_data; end
      if (bus.rsp_val && bus.rsp_rdy) begin
        tb_busy <= 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // Per-cycle comparison against the bench's view of the transaction.
  always @(negedge clk) begin
    if (!reset) begin
      check("cmd_rdy", bus.cmd_rdy, !tb_busy);
      check("sin", bus.sin, bus.sen ? bus.sout : 1'b0);
      check("val_op_and_commit_ack", bus.val_op & bus.commit_ack, 0);
      if (bus.val_op) check("data_in", bus.data_in, tb_cmd);
      if (bus.rsp_val) begin
        if (exp_q.size() == 0) check("rsp_unexpected", bus.rsp_val, 0);
        else begin
          check("rsp_err", bus.rsp_err, exp_q[0].err);
          check("rsp_data", bus.rsp_data, exp_q[0].data);
          check("rsp_scan", bus.rsp_scan, exp_q[0].scan);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] d, input bit sc);
    int n = 0;
    bus.cmd_val = 1'b1; bus.cmd_data = d; bus.cmd_scan = sc;
    while (!bus.cmd_rdy && n < 100) begin tick(); n++; end
    check("cmd_rdy_wait", bus.cmd_rdy, 1);
    tick();
    bus.cmd_val = 1'b0;
  endtask

  task automatic wait_rsp;
    int n = 0;
    while (!bus.rsp_val && n < 200) begin tick(); n++; end
    check("rsp_val_wait", bus.rsp_val, 1);
  endtask

  task automatic take_rsp;
    bus.rsp_rdy = 1'b1; tick(); bus.rsp_rdy = 1'b0;
  endtask

  initial begin : main
    int v0, c0, s0, e0, n;
    bus.cmd_val = 1'b0; bus.cmd_data = '0; bus.cmd_scan = 1'b0; bus.rsp_rdy = 1'b0;
    repeat (3) tick();
    check("rst_cmd_rdy", bus.cmd_rdy, 1);
    check("rst_rsp_val", bus.rsp_val, 0);
    check("rst_val_op", bus.val_op, 0);
    check("rst_sen", bus.sen, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_data_in", bus.data_in, 0);
    reset = 1'b0;
    tick();

    // 1: plain op, ack on third val_op cycle, commit three cycles later
    cfg_ack_at = 2; cfg_commit_after = 3; cfg_dout = 32'h6; cfg_both = 0;
    exp_q.push_back(model(2, 32'h6, 0, 32'h0));
    v0 = n_val; c0 = n_cack;
    send(32'h5, 0);
    wait_rsp();
    check("t1_rsp_data", bus.rsp_data, 32'h6);
    check("t1_rsp_err", bus.rsp_err, 0);
    check("t1_val_cycles", n_val - v0, 3);
    check("t1_commit_acks", n_cack - c0, 1);
    take_rsp();

    // 2: scan unload restores the chain
    chain_init = 32'hA5A5F00F; chain_ld = 1'b1; tick(); chain_ld = 1'b0;
    cfg_ack_at = 0; cfg_commit_after = 1; cfg_dout = 32'h22;
    exp_q.push_back(model(0, 32'h22, 1, 32'hA5A5F00F));
    s0 = n_sen; e0 = n_sce;
    send(32'h11, 1);
    wait_rsp();
    check("t2_rsp_scan", bus.rsp_scan, 32'hA5A5F00F);
    check("t2_chain", chain, 32'hA5A5F00F);
    check("t2_sen_cycles", n_sen - s0, 32);
    check("t2_scan_ce_cycles", n_sce - e0, 32);
    check("t2_rsp_data", bus.rsp_data, 32'h22);
    take_rsp();

    // 3: no ack ever -> timeout
    cfg_ack_at = -1;
    exp_q.push_back(model(-1, 32'h0, 0, 32'h0));
    v0 = n_val; c0 = n_cack;
    send(32'h33, 0);
    wait_rsp();
    check("t3_val_cycles", n_val - v0, 16);
    check("t3_rsp_err", bus.rsp_err, 1);
    check("t3_rsp_data", bus.rsp_data, 0);
    check("t3_commit_acks", n_cack - c0, 0);
    take_rsp();

    // 4: ack and commit together, held two cycles
    cfg_ack_at = 1; cfg_both = 1; cfg_dout = 32'hFFFFFFFF;
    exp_q.push_back(model(1, 32'hFFFFFFFF, 0, 32'h0));
    c0 = n_cack;
    send(32'h44, 0);
    wait_rsp();
    check("t4_commit_acks", n_cack - c0, 1);
    check("t4_rsp_data", bus.rsp_data, 32'hFFFFFFFF);
    check("t4_rsp_err", bus.rsp_err, 0);
    take_rsp();

    // 5: response backpressure with a second command waiting
    cfg_ack_at = 0; cfg_both = 0; cfg_commit_after = 1; cfg_dout = 32'h55;
    exp_q.push_back(model(0, 32'h55, 0, 32'h0));
    exp_q.push_back(model(0, 32'h55, 0, 32'h0));
    send(32'h50, 0);
    wait_rsp();
    bus.cmd_val = 1'b1; bus.cmd_data = 32'h66; bus.cmd_scan = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_rsp_val_held", bus.rsp_val, 1);
      check("t5_rsp_data_held", bus.rsp_data, 32'h55);
      check("t5_cmd_rdy_low", bus.cmd_rdy, 0);
    end
    take_rsp();
    check("t5_cmd_rdy_after", bus.cmd_rdy, 1);
    tick();
    bus.cmd_val = 1'b0;
    check("t5_second_accepted", bus.val_op, 1);
    check("t5_second_data_in", bus.data_in, 32'h66);
    wait_rsp();
    take_rsp();

    // 6: reset in the middle of the scan
    chain_init = 32'h12345678; chain_ld = 1'b1; tick(); chain_ld = 1'b0;
    exp_q.push_back(model(0, 32'h55, 1, 32'h12345678));
    send(32'h77, 1);
    n = 0;
    while (!bus.sen && n < 100) begin tick(); n++; end
    check("t6_scan_started", bus.sen, 1);
    repeat (6) tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("t6_cmd_rdy", bus.cmd_rdy, 1);
    check("t6_val_op", bus.val_op, 0);
    check("t6_commit_ack", bus.commit_ack, 0);
    check("t6_sen", bus.sen, 0);
    check("t6_scan_ce", bus.scan_ce, 0);
    check("t6_sin", bus.sin, 0);
    check("t6_rsp_val", bus.rsp_val, 0);
    check("t6_rsp_err", bus.rsp_err, 0);
    check("t6_rsp_data", bus.rsp_data, 0);
    check("t6_rsp_scan", bus.rsp_scan, 0);
    check("t6_data_in", bus.data_in, 0);
    tick();
    check("t6_idle_holds", bus.cmd_rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
